// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and sequencer for a single-port
// scratch memory. The memory has a registered read and pulses `stored` to
// acknowledge a write.
//
// Ports:
//   clk, reset            clock and synchronous active-low reset
//   reqN/rwN/addrN/wdataN requester N: level request held until ackN,
//                         direction (1 = read), address, write data
//   gntN                  one-cycle pulse when the request is accepted and latched
//   ackN/rdataN/errN      one-cycle completion pulse; read data is held until
//                         the next ackN; err reports a bad address or a
//                         missing write acknowledge
//   mem_*                 pins to the memory (en, r_w, abus, dbus_in1,
//                         dbus_out1, stored)
//   busy                  high whenever the sequencer is not IDLE
//   last_grant            port of the most recently completed grant
//   dbg_state             current sequencer state, for observation only
//
// Handshake: a requester raises reqN and holds it with stable rw/addr/wdata
// until gntN. It keeps reqN high until ackN and drops it in the cycle after
// ackN. The sequencer only looks at requests in IDLE.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              rw0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,
    input  logic              req1,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,
    output logic              mem_en,
    output logic              mem_r_w,
    output logic [ADDR_W-1:0] mem_abus,
    output logic [DATA_W-1:0] mem_dbus_in,
    input  logic [DATA_W-1:0] mem_dbus_out,
    input  logic              mem_stored,
    output logic              busy,
    output logic              last_grant,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t state;
    logic   sel;      // port being served
    logic   lat_rw;   // latched direction of the access in flight
    logic   lat_err;  // latched address error; the error path skips the memory

    // Arbitration result for the current cycle. Only used in IDLE.
    logic              pick;
    logic              p_rw;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              p_bad;

    always_comb begin
        pick    = 1'b0;
        p_rw    = rw0;
        p_addr  = addr0;
        p_wdata = wdata0;
        // Under contention the port that did not win last time goes next.
        if (req0 && req1) begin
            pick = ~last_grant;
        end else begin
            pick = req1;
        end
        if (pick) begin
            p_rw    = rw1;
            p_addr  = addr1;
            p_wdata = wdata1;
        end
        p_bad = ({1'b0, p_addr} >= DEPTH_L);
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            sel         <= 1'b0;
            lat_rw      <= 1'b1;
            lat_err     <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            mem_en      <= 1'b0;
            mem_r_w     <= 1'b1;
            mem_abus    <= '0;
            mem_dbus_in <= '0;
            busy        <= 1'b0;
            last_grant  <= 1'b1;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        sel    <= pick;
                        lat_rw <= p_rw;
                        gnt0   <= ~pick;
                        gnt1   <= pick;
                        busy   <= 1'b1;
                        if (p_bad) begin
                            lat_err <= 1'b1;
                            state   <= RESP;
                        end else begin
                            // The memory pins are loaded here so the enable
                            // appears in the same cycle as the grant.
                            lat_err     <= 1'b0;
                            mem_en      <= 1'b1;
                            mem_r_w     <= p_rw;
                            mem_abus    <= p_addr;
                            mem_dbus_in <= p_rw ? '0 : p_wdata;
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mem_en  <= 1'b0;
                    mem_r_w <= 1'b1;
                    state   <= WAIT;
                end
                WAIT: begin
                    // The memory output is only meaningful in this cycle;
                    // it floats while the memory is disabled.
                    if (lat_rw) begin
                        if (sel) rdata1 <= mem_dbus_out;
                        else     rdata0 <= mem_dbus_out;
                        err0 <= 1'b0;
                        err1 <= 1'b0;
                    end else begin
                        err0 <= ~sel & ~mem_stored;
                        err1 <= sel & ~mem_stored;
                    end
                    ack0       <= ~sel;
                    ack1       <= sel;
                    last_grant <= sel;
                    state      <= RESP;
                end
                RESP: begin
                    if (ack0 || ack1) begin
                        ack0  <= 1'b0;
                        ack1  <= 1'b0;
                        err0  <= 1'b0;
                        err1  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        // Arrived straight from IDLE on a bad address: the
                        // ack has not been issued yet, so issue it now.
                        ack0       <= ~sel;
                        ack1       <= sel;
                        err0       <= ~sel & lat_err;
                        err1       <= sel & lat_err;
                        last_grant <= sel;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
